// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch FSM feeding a DEPTH-entry instruction queue.
// Optional macro FETCH_ALIGN_CHECK_EN adds a sticky fetch_err output for misaligned program counters.
module instr_fetch_unit #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  pc_value,
    output logic          pc_enable,
    input  logic          flush,
    output logic          mem_req,
    output logic [N-1:0]  mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          instr_valid,
    output logic [31:0]   instr,
    output logic [N-1:0]  instr_pc,
    input  logic          instr_ready
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic          fetch_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [N-1:0]    addr_r;
    logic [CW-1:0]   count_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [31:0]     data_mem_r [DEPTH];
    logic [N-1:0]    pc_mem_r   [DEPTH];

    logic            push_s;
    logic            pop_s;
    logic            misaligned_s;
    logic            can_issue_s;
    logic            load_s;

`ifdef FETCH_ALIGN_CHECK_EN
    logic            fetch_err_r;
    assign misaligned_s = fetch_err_r | (pc_value[1:0] != 2'b00);
    assign fetch_err    = fetch_err_r;
`else
    assign misaligned_s = 1'b0;
`endif

    assign push_s      = (state_r == FETCH) & mem_ack & ~flush;
    assign pop_s       = (count_r != {CW{1'b0}}) & instr_ready & ~flush;
    assign can_issue_s = ~flush & ~misaligned_s & (count_r < CW'(DEPTH));
    assign load_s      = (state_r == IDLE) & can_issue_s;

    assign mem_req     = (state_r != IDLE);
    assign mem_addr    = addr_r;
    assign instr_valid = (count_r != {CW{1'b0}});
    assign instr       = data_mem_r[rd_ptr_r];
    assign instr_pc    = pc_mem_r[rd_ptr_r];

    // Next-state decode and the combinational PC load strobe.
    always_comb begin
        state_s   = state_r;
        pc_enable = flush | push_s;
        case (state_r)
            IDLE: begin
                if (can_issue_s) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    state_s = IDLE;
                end else if (flush) begin
                    state_s = DISCARD;
                end else begin
                    state_s = FETCH;
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = DISCARD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state and request address; the address only moves when a new fetch is launched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            addr_r  <= {N{1'b0}};
        end else begin
            state_r <= state_s;
            if (load_s) begin
                addr_r <= pc_value;
            end
        end
    end

    // Queue occupancy and pointers; a flush empties the queue regardless of a same-cycle pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else if (flush) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents outside the valid window are masked by instr_valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= mem_rdata;
            pc_mem_r[wr_ptr_r]   <= addr_r;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misalignment flag, raised while idle and cleared only by a redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_err_r <= 1'b0;
        end else if (flush) begin
            fetch_err_r <= 1'b0;
        end else if ((state_r == IDLE) && (pc_value[1:0] != 2'b00)) begin
            fetch_err_r <= 1'b1;
        end else begin
            fetch_err_r <= fetch_err_r;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model. Honors FETCH_ALIGN_CHECK_EN.
module tb_instr_fetch_unit;
    localparam int N     = 32;
    localparam int DEPTH = 4;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  pc_value;
    logic          pc_enable;
    logic          flush;
    logic          mem_req;
    logic [N-1:0]  mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [N-1:0]  instr_pc;
    logic          instr_ready;
`ifdef FETCH_ALIGN_CHECK_EN
    logic          fetch_err;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_value(pc_value), .pc_enable(pc_enable),
        .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready)
`ifdef FETCH_ALIGN_CHECK_EN
        , .fetch_err(fetch_err)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: outstanding request, discard flag, sticky error and a queue of {instr, pc}
    bit            m_busy, m_disc, m_err;
    logic [N-1:0]  m_addr;
    int            m_age;
    logic [N+31:0] m_q[$];

    int            ack_delay = 0;
    bit            rnd_mode = 1'b0;
    bit            fixed_rd_en = 1'b0;
    logic [31:0]   fixed_rd = 32'h0;
    logic [N-1:0]  flush_target = 32'h00400100;
    int            pe_seen = 0;
    int            push_seen = 0;
    logic          exp_pe;
    logic [N-1:0]  next_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_auto();
        if (rnd_mode) mem_ack = ($urandom_range(0, 2) == 0);
        else          mem_ack = m_busy && (m_age >= ack_delay);
        if (fixed_rd_en)   mem_rdata = fixed_rd;
        else if (rnd_mode) mem_rdata = $urandom;
        else               mem_rdata = {m_addr[15:0], ~m_addr[15:0]};
    endtask

    // One clock: compare at negedge, advance model, apply PC-register load after posedge
    task automatic cycle();
        int  was_size;
        bit  mis, old_err, was_busy;
        @(negedge clk);
        exp_pe = 1'b0;
        if (!reset) begin
            m_busy = 1'b0; m_disc = 1'b0; m_err = 1'b0; m_q.delete(); m_age = 0;
            check("rst_mem_req", mem_req, 1'b0);
            check("rst_instr_valid", instr_valid, 1'b0);
            check("rst_pc_enable", pc_enable, flush);
        end else begin
            exp_pe = flush | (m_busy & ~m_disc & mem_ack);
            check("mem_req", mem_req, m_busy);
            if (m_busy) check("mem_addr", mem_addr, m_addr);
            check("pc_enable", pc_enable, exp_pe);
            check("instr_valid", instr_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                check("instr", instr, m_q[0][N+31:N]);
                check("instr_pc", instr_pc, m_q[0][N-1:0]);
            end
`ifdef FETCH_ALIGN_CHECK_EN
            check("fetch_err", fetch_err, m_err);
`endif
            pe_seen   += int'(pc_enable);
            push_seen += int'(pc_enable & ~flush);
            was_size = m_q.size();
            was_busy = m_busy;
            if (flush) m_q.delete();
            else begin
                if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
                if (m_busy && mem_ack && !m_disc) m_q.push_back({mem_rdata, m_addr});
            end
            mis = ALIGN && (pc_value[1:0] != 2'b00);
            old_err = m_err;
            if (flush) m_err = 1'b0;
            else if (!was_busy && mis) m_err = 1'b1;
            if (was_busy) begin
                if (mem_ack) begin m_busy = 1'b0; m_disc = 1'b0; end
                else begin
                    if (flush) m_disc = 1'b1;
                    m_age++;
                end
            end else if (!flush && !old_err && !mis && was_size < DEPTH) begin
                m_busy = 1'b1; m_addr = pc_value; m_age = 0;
            end
            next_pc = flush ? flush_target : pc_value + 32'd4;
        end
        @(posedge clk);
        #1;
        if (exp_pe) pc_value = next_pc;
    endtask

    // Asynchronous reset applied mid-cycle, held for two clocks
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check("async_mem_req", mem_req, 1'b0);
        check("async_instr_valid", instr_valid, 1'b0);
        check("async_mem_addr", mem_addr, 32'h0);
        flush = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        pc_value = 32'h00400000;
    endtask

    initial begin
        logic [N-1:0] first_addr;
        bit got, hit;
        reset = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        instr_ready = 1'b0; pc_value = 32'h00400000;
        m_busy = 1'b0; m_disc = 1'b0; m_err = 1'b0; m_age = 0;
        @(posedge clk); #1;
        cycle();
        check("reset_mem_addr", mem_addr, 32'h0);
        cycle();
        reset = 1'b1;

        // Single fetch with two-cycle memory latency
        fixed_rd_en = 1'b1; fixed_rd = 32'h20080005; ack_delay = 2;
        pe_seen = 0; got = 1'b0; first_addr = '0;
        for (int i = 0; i < 5; i++) begin
            drive_auto();
            cycle();
            if (mem_req && !got) begin got = 1'b1; first_addr = mem_addr; end
        end
        check("t35_addr", first_addr, 32'h00400000);
        check("t35_pe_pulses", pe_seen, 1);
        check("t35_valid", instr_valid, 1'b1);
        check("t35_instr", instr, 32'h20080005);
        check("t35_instr_pc", instr_pc, 32'h00400000);
        fixed_rd_en = 1'b0;
        do_reset();

        // Fill the queue with the decoder stalled, then one pop resumes fetching
        ack_delay = 0; push_seen = 0;
        for (int i = 0; i < 12; i++) begin drive_auto(); cycle(); end
        check("t36_pushes", push_seen, 4);
        check("t36_stalled_req", mem_req, 1'b0);
        check("t36_head_pc", instr_pc, 32'h00400000);
        instr_ready = 1'b1; drive_auto(); cycle();
        instr_ready = 1'b0; drive_auto(); cycle();
        check("t36_resume_req", mem_req, 1'b1);
        check("t36_resume_addr", mem_addr, 32'h00400010);
        drive_auto(); cycle();
        do_reset();

        // Flush during an outstanding fetch: discard and resume at redirect target
        ack_delay = 3; flush_target = 32'h00400100;
        drive_auto(); cycle();
        pe_seen = 0;
        flush = 1'b1; drive_auto(); cycle(); flush = 1'b0;
        check("t37_held_req", mem_req, 1'b1);
        check("t37_held_addr", mem_addr, 32'h00400000);
        for (int i = 0; i < 3; i++) begin drive_auto(); cycle(); end
        check("t37_pe_pulses", pe_seen, 1);
        check("t37_no_valid", instr_valid, 1'b0);
        drive_auto(); cycle();
        check("t37_redirect_addr", mem_addr, 32'h00400100);
        do_reset();

        // Flush coincident with ack and pop while two entries are queued
        ack_delay = 1; hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            drive_auto();
            if (m_q.size() == 2 && m_busy && mem_ack) begin
                flush = 1'b1; instr_ready = 1'b1; hit = 1'b1; pe_seen = 0;
            end
            cycle();
        end
        flush = 1'b0; instr_ready = 1'b0;
        check("t38_reached", hit, 1'b1);
        check("t38_pe_pulses", pe_seen, 1);
        check("t38_emptied", instr_valid, 1'b0);
        do_reset();

        // Reset in the middle of a fetch, then a stray ack
        ack_delay = 0;
        for (int i = 0; i < 4; i++) begin drive_auto(); cycle(); end
        ack_delay = 5;
        drive_auto(); cycle();
        check("t39_busy_before", mem_req, 1'b1);
        do_reset();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; cycle();
        check("t39_stray_ignored", instr_valid, 1'b0);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned PC raises a sticky error until a redirect clears it
        do_reset();
        ack_delay = 0; pc_value = 32'h00400002;
        for (int i = 0; i < 4; i++) begin drive_auto(); cycle(); end
        check("t40_err", fetch_err, 1'b1);
        check("t40_no_req", mem_req, 1'b0);
        flush_target = 32'h00400000; flush = 1'b1; drive_auto(); cycle(); flush = 1'b0;
        check("t40_err_cleared", fetch_err, 1'b0);
        drive_auto(); cycle();
        check("t40_resume_req", mem_req, 1'b1);
        check("t40_resume_addr", mem_addr, 32'h00400000);
`endif

        // Randomized traffic
        do_reset();
        rnd_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive_auto();
            instr_ready = ($urandom_range(0, 1) == 1);
            flush = ($urandom_range(0, 11) == 0);
            flush_target = $urandom;
            if ($urandom_range(0, 3) != 0) flush_target[1:0] = 2'b00;
            cycle();
        end
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
